// File: rtl/alu_rr_scheduler.sv
// alu_rr_scheduler: round-robin sharing of one combinational ALU between two requesters.
// Latency: accept to resp_valid = WAIT+1 cycles for a legal op, 1 cycle for an illegal op.
// Backpressure: req*_ready only in IDLE; a held response blocks new grants until resp_ready.
// Optional feature macro: ALU_SCHED_STATS_EN adds grant_cnt0/grant_cnt1/err_cnt counters.
module alu_rr_scheduler #(
    parameter int W      = 4,
    parameter int SW     = 4,
    parameter int WAIT   = 1,
    parameter int MAX_OP = 13
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    input  logic [W-1:0]  req0_a,
    input  logic [W-1:0]  req0_b,
    input  logic [SW-1:0] req0_s,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [W-1:0]  req1_a,
    input  logic [W-1:0]  req1_b,
    input  logic [SW-1:0] req1_s,
    output logic          req1_ready,
    output logic [W-1:0]  alu_a,
    output logic [W-1:0]  alu_b,
    output logic [SW-1:0] alu_s,
    input  logic [W-1:0]  alu_y,
    input  logic          alu_cout,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic [W-1:0]  resp_y,
    output logic          resp_cout,
    output logic          resp_id,
`ifdef ALU_SCHED_STATS_EN
    output logic [15:0]   grant_cnt0,
    output logic [15:0]   grant_cnt1,
    output logic [7:0]    err_cnt,
`endif
    output logic          resp_err
);

    localparam int CW = 4;
    localparam logic [SW-1:0] MAX_OP_V = SW'(MAX_OP);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t         state_q;
    logic           last_grant_q;
    logic           hold_q;      // one dead IDLE cycle after each response handshake
    logic           op_id_q;
    logic [CW-1:0]  cnt_q;
    logic [W-1:0]   alu_a_q;
    logic [W-1:0]   alu_b_q;
    logic [SW-1:0]  alu_s_q;
    logic           resp_valid_q;
    logic [W-1:0]   resp_y_q;
    logic           resp_cout_q;
    logic           resp_id_q;
    logic           resp_err_q;

    logic           gnt_en;
    logic           gnt_id;
    logic [W-1:0]   gnt_a;
    logic [W-1:0]   gnt_b;
    logic [SW-1:0]  gnt_s;
    logic           gnt_illegal;

    // Round-robin pick: on contention the requester that did not win last time goes next.
    always_comb begin
        gnt_en = (state_q == ST_IDLE) && !hold_q && !rst && (req0_valid || req1_valid);
        if (req0_valid && req1_valid) begin
            gnt_id = ~last_grant_q;
        end else begin
            gnt_id = req1_valid;
        end
        gnt_a       = gnt_id ? req1_a : req0_a;
        gnt_b       = gnt_id ? req1_b : req0_b;
        gnt_s       = gnt_id ? req1_s : req0_s;
        gnt_illegal = (gnt_s > MAX_OP_V);
    end

    assign req0_ready = gnt_en & ~gnt_id;
    assign req1_ready = gnt_en &  gnt_id;

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_s      = alu_s_q;
    assign resp_valid = resp_valid_q;
    assign resp_y     = resp_y_q;
    assign resp_cout  = resp_cout_q;
    assign resp_id    = resp_id_q;
    assign resp_err   = resp_err_q;

    // Scheduler FSM: grant, hold ALU inputs for WAIT cycles, capture, hand back the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            hold_q       <= 1'b0;
            op_id_q      <= 1'b0;
            cnt_q        <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_s_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_y_q     <= '0;
            resp_cout_q  <= 1'b0;
            resp_id_q    <= 1'b0;
            resp_err_q   <= 1'b0;
        end else begin
            hold_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (gnt_en) begin
                        last_grant_q <= gnt_id;
                        op_id_q      <= gnt_id;
                        if (gnt_illegal) begin
                            // Illegal select never reaches the ALU bus.
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_y_q     <= '0;
                            resp_cout_q  <= 1'b0;
                            resp_id_q    <= gnt_id;
                            state_q      <= ST_RESP;
                        end else begin
                            alu_a_q <= gnt_a;
                            alu_b_q <= gnt_b;
                            alu_s_q <= gnt_s;
                            cnt_q   <= CW'(WAIT);
                            state_q <= ST_EXEC;
                        end
                    end
                end
                ST_EXEC: begin
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        resp_valid_q <= 1'b1;
                        resp_y_q     <= alu_y;
                        resp_cout_q  <= alu_cout;
                        resp_id_q    <= op_id_q;
                        resp_err_q   <= 1'b0;
                        state_q      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        hold_q       <= 1'b1;
                        state_q      <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef ALU_SCHED_STATS_EN
    logic [15:0] grant_cnt0_q;
    logic [15:0] grant_cnt1_q;
    logic [7:0]  err_cnt_q;

    assign grant_cnt0 = grant_cnt0_q;
    assign grant_cnt1 = grant_cnt1_q;
    assign err_cnt    = err_cnt_q;

    // Saturating per-requester grant counters and illegal-op counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_cnt0_q <= '0;
            grant_cnt1_q <= '0;
            err_cnt_q    <= '0;
        end else begin
            if (req0_ready && (grant_cnt0_q != 16'hFFFF)) begin
                grant_cnt0_q <= grant_cnt0_q + 16'd1;
            end
            if (req1_ready && (grant_cnt1_q != 16'hFFFF)) begin
                grant_cnt1_q <= grant_cnt1_q + 16'd1;
            end
            if (gnt_en && gnt_illegal && (err_cnt_q != 8'hFF)) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// tb_alu_rr_scheduler: directed bench with an in-bench ALU and a transaction-level scoreboard.
// Two requester drivers feed op queues; one monitor checks grants, latency and results each cycle.
// Response backpressure and reset are driven from the main sequence.
module tb_alu_rr_scheduler;

    localparam int W      = 4;
    localparam int SW     = 4;
    localparam int WAIT   = 1;
    localparam int MAX_OP = 13;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req1_valid;
    logic [W-1:0]  req0_a, req0_b, req1_a, req1_b;
    logic [SW-1:0] req0_s, req1_s;
    logic          req0_ready, req1_ready;
    logic [W-1:0]  alu_a, alu_b, alu_y;
    logic [SW-1:0] alu_s;
    logic          alu_cout;
    logic          resp_valid, resp_ready;
    logic [W-1:0]  resp_y;
    logic          resp_cout, resp_id, resp_err;

    alu_rr_scheduler #(.W(W), .SW(SW), .WAIT(WAIT), .MAX_OP(MAX_OP)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_s(req0_s), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_s(req1_s), .req1_ready(req1_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_y(alu_y), .alu_cout(alu_cout),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_y(resp_y), .resp_cout(resp_cout), .resp_id(resp_id), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    // Reference ALU: returns {cout, y}.
    function automatic logic [4:0] alu_ref(input logic [3:0] a, input logic [3:0] b, input logic [3:0] s);
        logic [4:0] r;
        case (s)
            4'd0:    r = {1'b0, a} + {1'b0, b};
            4'd1:    r = {(a < b), 4'(a - b)};
            4'd2:    r = {1'b0, 4'(4'd0 - a)};
            4'd3:    r = {1'b0, a} + 5'd1;
            4'd4:    r = {(a == 4'd0), 4'(a - 4'd1)};
            4'd5:    r = {1'b0, a & b};
            4'd6:    r = {1'b0, a | b};
            4'd7:    r = {1'b0, a ^ b};
            4'd8:    r = {1'b0, ~a};
            4'd9:    r = {a[3], a[2:0], 1'b0};
            4'd10:   r = {a[0], 1'b0, a[3:1]};
            4'd11:   r = {a[0], a[3], a[3:1]};
            4'd12:   r = {a[3], a[2:0], a[3]};
            4'd13:   r = {a[0], a[0], a[3:1]};
            default: r = 5'd0;
        endcase
        return r;
    endfunction

    assign {alu_cout, alu_y} = alu_ref(alu_a, alu_b, alu_s);

    typedef struct {
        logic [3:0] y;
        logic       cout;
        logic       id;
        logic       err;
        int         acc;
    } exp_t;

    exp_t        sb[$];
    logic [11:0] q0[$];
    logic [11:0] q1[$];
    logic        ids[$];
    int          accs[$];

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   next_ok = 0;
    int   nresp = 0;
    int   held = 0;
    int   max_held = 0;
    int   got_lat = 0;
    logic outst = 1'b0;
    logic [3:0] got_y;
    logic got_cout, got_id, got_err;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Requester 0 driver: presents queued ops, holds until accepted.
    initial begin : drv0
        logic t;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_s = '0;
        forever begin
            @(negedge clk);
            t = req0_valid && req0_ready;
            @(posedge clk);
            #1;
            if (t) req0_valid = 1'b0;
            if (!req0_valid && q0.size() > 0) begin
                {req0_a, req0_b, req0_s} = q0.pop_front();
                req0_valid = 1'b1;
            end
        end
    end

    // Requester 1 driver.
    initial begin : drv1
        logic t;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_s = '0;
        forever begin
            @(negedge clk);
            t = req1_valid && req1_ready;
            @(posedge clk);
            #1;
            if (t) req1_valid = 1'b0;
            if (!req1_valid && q1.size() > 0) begin
                {req1_a, req1_b, req1_s} = q1.pop_front();
                req1_valid = 1'b1;
            end
        end
    end

    // Monitor: arbitration model, scoreboard of expected responses, latency and stability.
    initial begin : monitor
        exp_t       e;
        logic       gid, eid, mlast, seen, permitted;
        logic [3:0] a, b, s;
        logic [6:0] snap;
        seen  = 1'b0;
        mlast = 1'b1;
        forever begin
            @(negedge clk);
            if (rst) begin
                sb.delete();
                seen    = 1'b0;
                mlast   = 1'b1;
                outst   = 1'b0;
                next_ok = cyc + 1;
            end else begin
                chk("alu_s_legal", 32'(alu_s <= 4'(MAX_OP)), 32'd1);
                chk("ready_excl", 32'(req0_ready && req1_ready), 32'd0);
                permitted = !outst && (cyc >= next_ok);
                chk("ready_rule", 32'(req0_ready || req1_ready), 32'(permitted && (req0_valid || req1_valid)));
                if (req0_ready || req1_ready) begin
                    gid = req1_ready;
                    eid = (req0_valid && req1_valid) ? !mlast : req1_valid;
                    chk("grant_id", 32'(gid), 32'(eid));
                    a = gid ? req1_a : req0_a;
                    b = gid ? req1_b : req0_b;
                    s = gid ? req1_s : req0_s;
                    e.id  = gid;
                    e.acc = cyc;
                    if (s > 4'(MAX_OP)) begin
                        e.err = 1'b1; e.y = 4'd0; e.cout = 1'b0;
                    end else begin
                        e.err = 1'b0;
                        {e.cout, e.y} = alu_ref(a, b, s);
                    end
                    sb.push_back(e);
                    accs.push_back(cyc);
                    mlast = gid;
                    outst = 1'b1;
                end
                if (resp_valid) begin
                    if (!seen) begin
                        seen = 1'b1;
                        held = 0;
                        snap = {resp_y, resp_cout, resp_id, resp_err};
                        if (sb.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL resp_unexpected: got resp_valid with no outstanding op, required none (t=%0t)", $time);
                        end else begin
                            got_lat = cyc - sb[0].acc;
                            chk("resp_latency", 32'(got_lat), sb[0].err ? 32'd1 : 32'(WAIT + 1));
                        end
                    end else begin
                        held++;
                        chk("resp_stable", 32'({resp_y, resp_cout, resp_id, resp_err}), 32'(snap));
                    end
                    if (resp_ready) begin
                        if (sb.size() > 0) begin
                            e = sb.pop_front();
                            chk("resp_y", 32'(resp_y), 32'(e.y));
                            chk("resp_cout", 32'(resp_cout), 32'(e.cout));
                            chk("resp_id", 32'(resp_id), 32'(e.id));
                            chk("resp_err", 32'(resp_err), 32'(e.err));
                        end
                        got_y    = resp_y;
                        got_cout = resp_cout;
                        got_id   = resp_id;
                        got_err  = resp_err;
                        ids.push_back(resp_id);
                        nresp++;
                        if (held > max_held) max_held = held;
                        seen    = 1'b0;
                        outst   = 1'b0;
                        next_ok = cyc + 2;
                    end
                end else if (seen) begin
                    checks++;
                    errors++;
                    $display("FAIL resp_dropped: resp_valid fell without handshake, required held (t=%0t)", $time);
                    seen = 1'b0;
                end
            end
        end
    end

    task automatic drain(input int budget, input string nm);
        int n;
        n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || req0_valid || req1_valid || outst) && n < budget) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL drain_%s: timed out after %0d cycles, required completion", nm, n);
        end
        repeat (3) @(posedge clk);
        #2;
    endtask

    initial begin : main
        int n;
        int nsnap;
        rst        = 1'b1;
        resp_ready = 1'b1;
        #2;
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_y", 32'(resp_y), 32'd0);
        chk("rst_resp_id", 32'(resp_id), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_alu_bus", 32'({alu_a, alu_b, alu_s}), 32'd0);
        chk("rst_ready", 32'({req0_ready, req1_ready}), 32'd0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #2;

        // Add on requester 0.
        q0.push_back({4'b1001, 4'b0001, 4'b0000});
        drain(100, "add");
        chk("add_y", 32'(got_y), 32'b1010);
        chk("add_cout", 32'(got_cout), 32'd0);
        chk("add_id", 32'(got_id), 32'd0);
        chk("add_err", 32'(got_err), 32'd0);
        chk("add_latency", 32'(got_lat), 32'd2);

        // Rotate left, then shift left, on requester 1.
        q1.push_back({4'b1001, 4'b0000, 4'b1100});
        drain(100, "rol");
        chk("rol_y", 32'(got_y), 32'b0011);
        chk("rol_id", 32'(got_id), 32'd1);
        q1.push_back({4'b1001, 4'b0000, 4'b1001});
        drain(100, "shl");
        chk("shl_y", 32'(got_y), 32'b0010);
        chk("shl_cout", 32'(got_cout), 32'd1);

        // Continuous contention: strict alternation at the minimum issue interval.
        ids.delete();
        accs.delete();
        for (int i = 0; i < 6; i++) begin
            q0.push_back({4'(i), 4'(i + 3), 4'd0});
            q1.push_back({4'(i + 7), 4'(i), 4'd7});
        end
        drain(400, "alt");
        chk("alt_count", 32'(ids.size()), 32'd12);
        for (int i = 0; i < ids.size(); i++) chk("alt_id", 32'(ids[i]), 32'(i % 2));
        for (int i = 0; i + 1 < accs.size(); i++) chk("alt_interval", 32'(accs[i + 1] - accs[i]), 32'(WAIT + 3));

        // Illegal select.
        q0.push_back({4'b0011, 4'b0101, 4'b1111});
        drain(100, "illegal");
        chk("ill_err", 32'(got_err), 32'd1);
        chk("ill_y", 32'(got_y), 32'd0);
        chk("ill_latency", 32'(got_lat), 32'd1);

        // Response backpressure with both requesters waiting.
        ids.delete();
        max_held   = 0;
        resp_ready = 1'b0;
        q0.push_back({4'b0110, 4'b0011, 4'b0001});
        q1.push_back({4'b1111, 4'b0001, 4'b0000});
        n = 0;
        while (!resp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("bp_resp_seen", 32'(resp_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid_held", 32'(resp_valid), 32'd1);
            chk("bp_no_ready", 32'({req0_ready, req1_ready}), 32'd0);
        end
        @(posedge clk);
        #1 resp_ready = 1'b1;
        drain(100, "bp");
        chk("bp_held_cycles", 32'(max_held >= 5), 32'd1);
        chk("bp_count", 32'(ids.size()), 32'd2);
        if (ids.size() == 2) begin
            chk("bp_first_id", 32'(ids[0]), 32'd1);
            chk("bp_next_other", 32'(ids[1]), 32'd0);
        end

        // Reset in the middle of EXEC drops the op.
        q0.push_back({4'b0110, 4'b0011, 4'b0000});
        n = 0;
        while (!outst && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rst_op_accepted", 32'(outst), 32'd1);
        nsnap = nresp;
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("mid_rst_resp", 32'({resp_y, resp_cout, resp_id, resp_err}), 32'd0);
        chk("mid_rst_alu_bus", 32'({alu_a, alu_b, alu_s}), 32'd0);
        chk("mid_rst_ready", 32'({req0_ready, req1_ready}), 32'd0);
        @(posedge clk);
        #3 rst = 1'b0;
        repeat (10) @(posedge clk);
        chk("rst_no_response", 32'(nresp), 32'(nsnap));
        #2;
        ids.delete();
        q0.push_back({4'b0001, 4'b0001, 4'b0000});
        q1.push_back({4'b0010, 4'b0001, 4'b0000});
        drain(100, "post_rst");
        chk("post_rst_count", 32'(ids.size()), 32'd2);
        if (ids.size() > 0) chk("post_rst_first", 32'(ids[0]), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        errors++;
        $display("FAIL global_timeout: simulation exceeded time limit, required completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_rr_scheduler.md
Name: alu_rr_scheduler

Overview:
- Shares one combinational 4-bit `alu` datapath between two requesters. Each requester supplies operands A, B and op-select S over a valid/ready handshake.
- Round-robin arbitration picks one request, drives the ALU operand/select bus from registered copies, waits a programmable settle time, captures y/Cout and returns them tagged with the requester ID over a valid/ready response channel.
- Sits between the per-client request logic and the `alu` instance. It is the only driver of the ALU A/B/S inputs.

Parameters:
- W, 4, operand/result width (matches the `alu` datapath).
- SW, 4, op-select width.
- WAIT, 1, cycles the ALU inputs are held stable before y/Cout is sampled (1..15).
- MAX_OP, 13, highest legal S encoding. Encodings 0..13 are, in order: Add, Diff, Twos, Inc, Dec, And, Or, Xor, Ones, Sh_left, Sh_right, Ar_right, Ro_left, Ro_right.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset.
- req0_valid  in  1  requester 0 has an op.
- req0_a  in  W  requester 0 operand A.
- req0_b  in  W  requester 0 operand B.
- req0_s  in  SW  requester 0 op-select.
- req0_ready  out  1  requester 0 op accepted this cycle.
- req1_valid, req1_a, req1_b, req1_s, req1_ready: same as requester 0, for requester 1.
- alu_a  out  W  to ALU A.
- alu_b  out  W  to ALU B.
- alu_s  out  SW  to ALU S.
- alu_y  in  W  ALU selected result y.
- alu_cout  in  1  ALU carry out.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts result.
- resp_y  out  W  captured result.
- resp_cout  out  1  captured carry.
- resp_id  out  1  requester that issued the op.
- resp_err  out  1  op-select exceeded MAX_OP; resp_y/resp_cout forced to 0.

Behaviour:
- Clocking/reset: one clock; reset is asynchronous and active-high.
- Reset values:
  - All outputs 0; state IDLE.
  - last_grant register = 1, so requester 0 wins the first contention.
  - Settle counter = 0.
- States:
  - IDLE:
    - If exactly one reqN_valid is high, grant N. If both are high, grant the requester != last_grant.
    - reqN_ready is high combinationally in the same cycle as the grant, and only in IDLE; it is never high for both requesters.
    - On the grant edge: latch a/b/s/id into op registers; last_grant <= N.
    - If latched s > MAX_OP, go to RESP with resp_err=1 and do not drive the ALU. Otherwise go to EXEC with counter = WAIT.
  - EXEC:
    - alu_a/alu_b/alu_s driven from the op registers (registered, glitch-free). Counter decrements each cycle.
    - When the counter reaches 1, sample alu_y/alu_cout into resp_y/resp_cout on that edge and go to RESP.
  - RESP:
    - resp_valid=1. resp_y, resp_cout, resp_id and resp_err stay stable until resp_ready is sampled high.
    - On handshake: resp_valid drops next cycle and state returns to IDLE. A new grant is possible on the cycle after return to IDLE.
- ALU bus outside EXEC: alu_a/alu_b/alu_s hold their last driven values; they are not zeroed. This avoids toggling the combinational ALU.
- Latency:
  - Accept edge to resp_valid = WAIT+1 cycles for a legal op; 1 cycle for an illegal op.
  - Minimum issue interval = WAIT+3 cycles when resp_ready is held high.
- Arithmetic: the scheduler does no arithmetic on data; y/Cout pass through unmodified. Width truncation and carry are the ALU's responsibility.
- Boundaries:
  - A request valid in EXEC/RESP waits (ready=0). Requesters must hold valid and data stable until ready.
  - Both valid continuously: grants strictly alternate 0,1,0,1.
  - resp_ready already high on the first RESP cycle: single-cycle RESP.
  - WAIT=1: ALU inputs stable for one full cycle before sampling.
  - rst asserted in EXEC or RESP: the in-flight op is dropped without a response; outputs return to reset values asynchronously.

Optional Feature:
- Macro ALU_SCHED_STATS_EN.
- Defined:
  - Adds outputs grant_cnt0 and grant_cnt1 (16 bits each) counting accepted ops per requester. They saturate at 16'hFFFF and clear on rst.
  - Adds output err_cnt (8 bits, saturating) counting resp_err responses.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Bench instantiates the real `alu` on the ALU bus. req0 A=4'b1001 B=4'b0001 S=4'b0000, resp_ready=1 -> resp_y=4'b1010, resp_cout=0, resp_id=0, resp_err=0, resp_valid exactly WAIT+1 cycles after accept.
- req1 A=4'b1001 S=4'b1100 (Ro_left) -> resp_y=4'b0011, resp_id=1. Then req1 S=4'b1001 (Sh_left) -> resp_y=4'b0010.
- Both requesters valid for 6 ops each, resp_ready=1 -> resp_id sequence 0,1,0,1,... with no request lost or duplicated.
- req0 S=4'b1111 -> resp_err=1, resp_y=0, response 1 cycle after accept; alu_s never equals 4'b1111.
- Response backpressure: hold resp_ready=0 for 5 cycles -> resp_valid and data stable, both req*_ready stay 0; release -> IDLE, and the next grant goes to the other requester.
- Assert rst mid-EXEC -> all outputs 0 immediately, no response for the dropped op; after release, first contention is granted to requester 0.
